// File: rtl/tri_bus_reader.sv
// Controlling end of a shared tri-state bus: selects one driver with break-before-make
// turnaround, lets the bus settle, and accepts a word only when two consecutive samples agree.
module tri_bus_reader #(
  parameter int WIDTH     = 4,
  parameter int NSRC      = 4,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3,
  localparam int SELW     = $clog2(NSRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [SELW-1:0]  src_sel,
  input  logic [WIDTH-1:0] bus_in,
  output logic [NSRC-1:0]  drv_en,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  // Handshake: req is a level sampled on a rising edge only while busy=0; a request seen
  // while busy is dropped, not queued. Completion is a single-cycle valid or err pulse.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_DRIVE   = 3'd2,
    S_SAMPLE1 = 3'd3,
    S_SAMPLE2 = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SELW-1:0]  sel_q;
  logic [3:0]       settle_cnt;
  logic [2:0]       retry_cnt;
  logic [WIDTH-1:0] s1_q;

  logic             samples_match;
  logic             retries_spent;
  logic             drive_nx;
  logic [NSRC-1:0]  sel_onehot;

  assign samples_match = (bus_in == s1_q);
  assign retries_spent = (retry_cnt == 3'(MAX_RETRY));

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (req) state_nx = S_TURN;
      S_TURN:    state_nx = S_DRIVE;
      S_DRIVE:   if (settle_cnt <= 4'd1) state_nx = S_SAMPLE1;
      S_SAMPLE1: state_nx = S_SAMPLE2;
      S_SAMPLE2: begin
        if (samples_match || retries_spent) state_nx = S_DONE;
        else                                state_nx = S_SAMPLE1;
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Enables are registered from the next state so they never glitch between drivers.
  always_comb begin
    drive_nx = 1'b0;
    case (state_nx)
      S_DRIVE, S_SAMPLE1, S_SAMPLE2: drive_nx = 1'b1;
      default:                       drive_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      drv_en     <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      err        <= 1'b0;
      data_out   <= '0;
      sel_q      <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
      s1_q       <= '0;
    end else begin
      state  <= state_nx;
      drv_en <= drive_nx ? sel_onehot : '0;
      busy   <= (state_nx != S_IDLE);
      valid  <= (state == S_SAMPLE2) && samples_match;
      err    <= (state == S_SAMPLE2) && !samples_match && retries_spent;

      if (state == S_IDLE && req) sel_q <= src_sel;

      if (state == S_TURN)       settle_cnt <= 4'(SETTLE);
      else if (state == S_DRIVE) settle_cnt <= settle_cnt - 4'd1;

      if (state == S_SAMPLE1) s1_q <= bus_in;

      if (state == S_SAMPLE2) begin
        if (samples_match)       data_out  <= bus_in;
        else if (!retries_spent) retry_cnt <= retry_cnt + 3'd1;
      end

      if (state == S_DONE) retry_cnt <= '0;
    end
  end

  a_drv_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(drv_en));
  a_valid_err:   assert property (@(posedge clk) disable iff (!rst_n) !(valid && err));

endmodule

// File: tb/tb_tri_bus_reader.sv
// Bench for tri_bus_reader: per-cycle output traces of each read are compared with a
// transaction-level model derived from the bus samples the driver presents.
module tb_tri_bus_reader;
  localparam int WIDTH     = 4;
  localparam int NSRC      = 4;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 3;
  localparam int SELW      = 2;
  localparam int NCYC      = 32;

  // Trace word layout: {drv_en, busy, valid, err, data_out}
  typedef logic [NSRC+3+WIDTH-1:0] tr_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [SELW-1:0]  src_sel = '0;
  logic [WIDTH-1:0] bus_in = '0;
  logic [NSRC-1:0]  drv_en;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [WIDTH-1:0] bus_seq[NCYC];
  tr_t              obs_tr[NCYC];
  tr_t              exp_tr[NCYC];
  logic [WIDTH-1:0] ref_data = '0;

  tri_bus_reader #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_sel(src_sel), .bus_in(bus_in),
    .drv_en(drv_en), .data_out(data_out), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: cycle c is the interval after edge c-1, edge 0 accepts the request.
  // Pair k samples the bus at the ends of cycles SETTLE+2+2k and SETTLE+3+2k; the read
  // finishes (valid or err) two cycles after the deciding pair.
  task automatic model_read(input logic [SELW-1:0] sel, output int d);
    int r;
    bit ok;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] new_data;
    logic [NSRC-1:0]  e_drv;
    ok = 1'b0;
    s2 = '0;
    for (r = 0; r <= MAX_RETRY; r++) begin
      s2 = bus_seq[SETTLE+3+2*r];
      if (bus_seq[SETTLE+2+2*r] == s2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) r = MAX_RETRY;
    d = SETTLE + 4 + 2*r;
    new_data = ok ? s2 : ref_data;
    for (int c = 0; c <= d; c++) begin
      e_drv = '0;
      if (c >= 2 && c < d) e_drv[sel] = 1'b1;
      exp_tr[c] = {e_drv, (c >= 1), (c == d) && ok, (c == d) && !ok,
                   (c == d) ? new_data : ref_data};
    end
    ref_data = new_data;
  endtask

  task automatic drive_read(input logic [SELW-1:0] sel, input bit hold,
                            input logic [SELW-1:0] other_sel, input int d);
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      obs_tr[c] = {drv_en, busy, valid, err, data_out};
      bus_in = bus_seq[c];
      if (c == 0) begin
        req = 1'b1;
        src_sel = sel;
      end else if (hold) begin
        req = 1'b1;
        src_sel = other_sel;
      end else begin
        req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    int d;
    req = 1'b1;
    src_sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({drv_en, busy, valid, err, data_out} !== tr_t'(0)) begin
        n_mis++;
        $display("FAIL reset_outputs: got %b want %b", {drv_en, busy, valid, err, data_out}, tr_t'(0));
      end
    end
    req = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < NCYC; c++) bus_seq[c] = 4'h5;
    model_read(2'd2, d);
    drive_read(2'd2, 1'b0, 2'd0, d);
    for (int c = 0; c <= d; c++) begin
      n_cmp++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_mis++;
        $display("FAIL first_read cycle %0d: got %b want %b", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int d;
    logic [SELW-1:0] sels[2];
    logic [WIDTH-1:0] vals[2];
    sels[0] = 2'd0; sels[1] = 2'd3;
    vals[0] = 4'hF; vals[1] = 4'h3;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCYC; c++) bus_seq[c] = vals[k];
      model_read(sels[k], d);
      drive_read(sels[k], 1'b0, 2'd0, d);
      for (int c = 0; c <= d; c++) begin
        n_cmp++;
        if (obs_tr[c] !== exp_tr[c]) begin
          n_mis++;
          $display("FAIL back_to_back[%0d] cycle %0d: got %b want %b", k, c, obs_tr[c], exp_tr[c]);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int d;
    for (int c = 0; c < NCYC; c++) bus_seq[c] = (c <= SETTLE + 2) ? 4'h6 : 4'h7;
    model_read(2'd1, d);
    drive_read(2'd1, 1'b0, 2'd0, d);
    for (int c = 0; c <= d; c++) begin
      n_cmp++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_mis++;
        $display("FAIL glitch cycle %0d: got %b want %b", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_toggle;
    int d;
    for (int c = 0; c < NCYC; c++) bus_seq[c] = c[0] ? 4'hA : 4'h5;
    model_read(2'd3, d);
    drive_read(2'd3, 1'b0, 2'd0, d);
    for (int c = 0; c <= d; c++) begin
      n_cmp++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_mis++;
        $display("FAIL toggle cycle %0d: got %b want %b", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_ignored_req;
    int d;
    for (int c = 0; c < NCYC; c++) bus_seq[c] = 4'hC;
    model_read(2'd1, d);
    drive_read(2'd1, 1'b1, 2'd2, d);
    for (int c = 0; c <= d; c++) begin
      n_cmp++;
      if (obs_tr[c] !== exp_tr[c]) begin
        n_mis++;
        $display("FAIL ignored_req cycle %0d: got %b want %b", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_reset_mid;
    tr_t in_drive;
    for (int c = 0; c < NCYC; c++) bus_seq[c] = 4'h9;
    drive_read(2'd1, 1'b0, 2'd0, 3);
    in_drive = {4'b0010, 1'b1, 1'b0, 1'b0, ref_data};
    n_cmp++;
    if (obs_tr[3] !== in_drive) begin
      n_mis++;
      $display("FAIL mid_reset_pre: got %b want %b", obs_tr[3], in_drive);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({drv_en, busy, valid, err, data_out} !== tr_t'(0)) begin
      n_mis++;
      $display("FAIL mid_reset_async: got %b want %b", {drv_en, busy, valid, err, data_out}, tr_t'(0));
    end
    ref_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    int d;
    int gap;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] other;
    logic [WIDTH-1:0] base;
    bit hold;
    for (int n = 0; n < 30; n++) begin
      sel   = SELW'($urandom_range(0, NSRC-1));
      other = SELW'($urandom_range(0, NSRC-1));
      hold  = 1'($urandom_range(0, 1));
      base  = WIDTH'($urandom);
      for (int c = 0; c < NCYC; c++)
        bus_seq[c] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : base;
      model_read(sel, d);
      drive_read(sel, hold, other, d);
      for (int c = 0; c <= d; c++) begin
        n_cmp++;
        if (obs_tr[c] !== exp_tr[c]) begin
          n_mis++;
          $display("FAIL random[%0d] cycle %0d: got %b want %b", n, c, obs_tr[c], exp_tr[c]);
        end
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        req = 1'b0;
        n_cmp++;
        if ({drv_en, busy, valid, err, data_out} !== {4'b0000, 3'b000, ref_data}) begin
          n_mis++;
          $display("FAIL random_gap[%0d]: got %b want %b", n,
                   {drv_en, busy, valid, err, data_out}, {4'b0000, 3'b000, ref_data});
        end
      end
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b0;
      n_cmp++;
      if ({drv_en, busy, valid, err, data_out} !== {4'b0000, 3'b000, ref_data}) begin
        n_mis++;
        $display("FAIL idle: got %b want %b", {drv_en, busy, valid, err, data_out},
                 {4'b0000, 3'b000, ref_data});
      end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_glitch;
    test_toggle;
    test_ignored_req;
    test_idle;
    test_reset_mid;
    test_idle;
    test_random;
    test_idle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
